// File: rtl/mips32_pkg.sv
// mips32_pkg: types and constants shared by the MIPS32 pipeline and its result-dump engine
package mips32_pkg;
  localparam int DATA_W_DFLT = 32;
  localparam int ADDR_W_DFLT = 5;
  localparam logic [5:0] OP_HLT = 6'b111111;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WT, S_SEND, S_SUM, S_DONE} dump_state_e;
endpackage

// File: rtl/mips32_result_dump.sv
// mips32_result_dump: on a HALTED rising edge, reads R0..NUM_REGS-1 and streams (idx,value) beats
//   clk1/rst_n            : clock, async active-low reset
//   halted                : core halted level; a rising edge starts one dump
//   rf_rd_en/rf_rd_addr   : register-file read request; rf_rd_data returns one cycle later
//   dump_valid/dump_ready : beat handshake carrying dump_idx, dump_data, dump_sum
//   dump_done             : one-cycle pulse after the final beat is accepted
//   MIPS32_DUMP_CHECKSUM_EN: when defined, appends an XOR checksum beat (dump_sum=1)
module mips32_result_dump
  import mips32_pkg::*;
#(
  parameter int NUM_REGS = 6,
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int ADDR_W   = ADDR_W_DFLT
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  output logic              rf_rd_en,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_sum,
  output logic              dump_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  dump_state_e       r_state;
  logic              r_halted_q, r_armed, r_abort, r_rd_en, r_valid, r_done;
  logic [ADDR_W-1:0] r_idx, r_dump_idx;
  logic [DATA_W-1:0] r_data;
  logic              w_start, w_hs, w_stop, w_last;
`ifdef MIPS32_DUMP_CHECKSUM_EN
  logic              r_sum;
  logic [DATA_W-1:0] r_acc;
  assign dump_sum = r_sum;
`else
  assign dump_sum = 1'b0;
`endif
  // r_armed blocks a dump on the first cycle after reset, so a halted level
  // already high through reset is not mistaken for a fresh rising edge
  assign w_start = halted & ~r_halted_q & r_armed;
  assign w_hs    = r_valid & dump_ready;
  // a halted drop seen while a beat was stalled is remembered in r_abort
  assign w_stop  = r_abort | ~halted;
  assign w_last  = r_idx == LAST;
  assign rf_rd_en   = r_rd_en;
  assign rf_rd_addr = r_idx;
  assign dump_valid = r_valid;
  assign dump_idx   = r_dump_idx;
  assign dump_data  = r_data;
  assign dump_done  = r_done;
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_halted_q <= 1'b0;
      r_armed    <= 1'b0;
      r_abort    <= 1'b0;
      r_rd_en    <= 1'b0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_dump_idx <= '0;
      r_data     <= '0;
`ifdef MIPS32_DUMP_CHECKSUM_EN
      r_sum      <= 1'b0;
      r_acc      <= '0;
`endif
    end else begin
      r_halted_q <= halted;
      r_armed    <= 1'b1;
      r_rd_en    <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_idx   <= '0;
          r_abort <= 1'b0;
          r_rd_en <= 1'b1;
          r_state <= S_RD;
`ifdef MIPS32_DUMP_CHECKSUM_EN
          r_acc   <= '0;
`endif
        end
        S_RD: r_state <= halted ? S_WT : S_IDLE;
        S_WT: if (!halted) r_state <= S_IDLE;
        else begin
          r_data     <= rf_rd_data;
          r_dump_idx <= r_idx;
          r_valid    <= 1'b1;
          r_state    <= S_SEND;
`ifdef MIPS32_DUMP_CHECKSUM_EN
          r_acc      <= r_acc ^ rf_rd_data;
`endif
        end
        S_SEND: if (w_hs) begin
          r_valid <= 1'b0;
          if (w_stop) r_state <= S_IDLE;
          else if (w_last) begin
`ifdef MIPS32_DUMP_CHECKSUM_EN
            r_valid    <= 1'b1;
            r_sum      <= 1'b1;
            r_dump_idx <= '0;
            r_data     <= r_acc;
            r_state    <= S_SUM;
`else
            r_done     <= 1'b1;
            r_state    <= S_DONE;
`endif
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_rd_en <= 1'b1;
            r_state <= S_RD;
          end
        end else if (!halted) r_abort <= 1'b1;
`ifdef MIPS32_DUMP_CHECKSUM_EN
        S_SUM: if (w_hs) begin
          r_valid <= 1'b0;
          r_sum   <= 1'b0;
          r_done  <= ~w_stop;
          r_state <= w_stop ? S_IDLE : S_DONE;
        end else if (!halted) r_abort <= 1'b1;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
